// File: rtl/udp_tx_buf.sv
// UDP transmit packet buffer: packs a byte stream big-endian into RAM
// words and replays them to the transmitter one word per request.
module udp_tx_buf #(
  parameter int ADDR_W    = 9,
  parameter int MAX_BYTES = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        drop,
  output logic        busy,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done
);

  typedef enum logic [1:0] {
    FILL,
    START,
    SEND
  } state_t;

  state_t      r_state;
  logic [31:0] r_ram [2**ADDR_W];
  logic [15:0] r_byte_cnt;
  logic [15:0] r_rd_idx;
  logic [31:0] r_word;
  logic        r_drop_flag;
  logic        r_wr_ready;
  logic        r_drop;
  logic        r_busy;
  logic        r_start;
  logic [15:0] r_byte_num;
  logic [31:0] r_tx_data;

  logic              w_acc;
  logic              w_ovf;
  logic              w_we;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [15:0]       w_nwords;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;

  assign w_acc    = wr_en & r_wr_ready & (r_state == FILL);
  assign w_lane   = r_byte_cnt[1:0];
  assign w_ovf    = r_drop_flag | (r_byte_cnt == 16'(MAX_BYTES));
  assign w_we     = w_acc & ~w_ovf & ((w_lane == 2'd3) | wr_last);
  assign w_waddr  = r_byte_cnt[ADDR_W+1:2];
  assign w_raddr  = r_rd_idx[ADDR_W-1:0];
  assign w_nwords = {2'b00, r_byte_num[15:2]}
                  + {15'd0, |r_byte_num[1:0]};

  // Lanes below the current one stay zero, so a short last word is padded.
  always_comb begin
    w_word = (w_lane == 2'd0) ? 32'h0 : r_word;
    unique case (w_lane)
      2'd0: w_word[31:24] = wr_data;
      2'd1: w_word[23:16] = wr_data;
      2'd2: w_word[15:8]  = wr_data;
      2'd3: w_word[7:0]   = wr_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_byte_cnt  <= '0;
      r_rd_idx    <= '0;
      r_word      <= '0;
      r_drop_flag <= 1'b0;
      r_wr_ready  <= 1'b1;
      r_drop      <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_byte_num  <= '0;
      r_tx_data   <= '0;
    end else begin
      r_drop  <= 1'b0;
      r_start <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_acc) begin
            r_word <= w_word;
            if (wr_last && w_ovf) begin
              r_drop      <= 1'b1;
              r_drop_flag <= 1'b0;
              r_byte_cnt  <= '0;
            end else if (wr_last) begin
              r_byte_num <= r_byte_cnt + 16'd1;
              r_state    <= START;
              r_start    <= 1'b1;
              r_wr_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else if (w_ovf) begin
              r_drop_flag <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 16'd1;
            end
          end
        end
        START: begin
          r_rd_idx <= '0;
          r_state  <= SEND;
        end
        SEND: begin
          if (tx_req && (r_rd_idx < w_nwords)) begin
            r_tx_data <= r_ram[w_raddr];
            r_rd_idx  <= r_rd_idx + 16'd1;
          end
          if (tx_done) begin
            r_state    <= FILL;
            r_byte_cnt <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign wr_ready    = r_wr_ready;
  assign drop        = r_drop;
  assign busy        = r_busy;
  assign tx_start_en = r_start;
  assign tx_byte_num = r_byte_num;
  assign tx_data     = r_tx_data;

endmodule

// File: tb/tb_udp_tx_buf.sv
// Bench for udp_tx_buf: packet-level reference model plus directed
// packets with literal word expectations.
module tb_udp_tx_buf;

  localparam int MAXB = 1472;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        drop;
  logic        busy;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;

  udp_tx_buf #(
    .ADDR_W   (9),
    .MAX_BYTES(MAXB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .drop       (drop),
    .busy       (busy),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: 0 = filling, 1 = start cycle, 2 = sending.
  int          m_mode;
  int          m_rd;
  logic [7:0]  m_q[$];
  logic [7:0]  m_pkt[$];
  logic        e_start;
  logic        e_drop;
  logic [15:0] e_num;
  logic [31:0] e_data;

  function automatic logic [31:0] mword(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4 * k + j < m_pkt.size())
        w[31 - 8 * j -: 8] = m_pkt[4 * k + j];
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_rd = 0;
    m_q.delete();
    e_start = 1'b0;
    e_drop = 1'b0;
    e_num = '0;
    e_data = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        e_start = 1'b0;
        e_drop = 1'b0;
        case (m_mode)
          0: if (wr_en) begin
            m_q.push_back(wr_data);
            if (wr_last) begin
              if (m_q.size() > MAXB) begin
                e_drop = 1'b1;
              end else begin
                m_pkt = m_q;
                e_num = 16'(m_pkt.size());
                e_start = 1'b1;
                m_mode = 1;
              end
              m_q.delete();
            end
          end
          1: begin
            m_rd = 0;
            m_mode = 2;
          end
          default: begin
            if (tx_req && m_rd < (int'(e_num) + 3) / 4) begin
              e_data = mword(m_rd);
              m_rd++;
            end
            if (tx_done) m_mode = 0;
          end
        endcase
      end
    end
  end

  int n_start = 0;
  int n_drop = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("wr_ready", 32'(wr_ready), 32'(m_mode == 0));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("tx_start_en", 32'(tx_start_en), 32'(e_start));
      chk("drop", 32'(drop), 32'(e_drop));
      chk("tx_byte_num", 32'(tx_byte_num), 32'(e_num));
      chk("tx_data", tx_data, e_data);
      if (tx_start_en) n_start++;
      if (drop) n_drop++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wbytes(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      wr_en = 1'b1;
      wr_data = b[i];
      wr_last = (i == b.size() - 1);
      step();
    end
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic req();
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
  endtask

  task automatic done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " wr_ready"}, 32'(wr_ready), 32'd1);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " start"}, 32'(tx_start_en), 32'd0);
    chk({nm, " drop"}, 32'(drop), 32'd0);
    chk({nm, " num"}, 32'(tx_byte_num), 32'd0);
    chk({nm, " data"}, tx_data, 32'h0);
  endtask

  logic [7:0] bq[$];
  int s0;
  int d0;

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    step();
    step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    wbytes(bq);
    chk("p8 start", 32'(tx_start_en), 32'd1);
    chk("p8 num", 32'(tx_byte_num), 32'd8);
    chk("p8 ready", 32'(wr_ready), 32'd0);
    step();
    chk("p8 start once", 32'(tx_start_en), 32'd0);
    req();
    chk("p8 w0", tx_data, 32'h01020304);
    req();
    chk("p8 w1", tx_data, 32'h05060708);
    done();
    chk("p8 ready after done", 32'(wr_ready), 32'd1);

    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    wbytes(bq);
    chk("p5 num", 32'(tx_byte_num), 32'd5);
    step();
    req();
    chk("p5 w0", tx_data, 32'hAABBCCDD);
    req();
    chk("p5 w1", tx_data, 32'hEE000000);
    req();
    chk("p5 w2 hold", tx_data, 32'hEE000000);
    done();

    s0 = n_start;
    d0 = n_drop;
    bq.delete();
    for (int i = 0; i < MAXB + 1; i++) bq.push_back(8'(i * 7 + 3));
    wbytes(bq);
    step();
    step();
    chk("ovf drop once", 32'(n_drop - d0), 32'd1);
    chk("ovf no start", 32'(n_start - s0), 32'd0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    wbytes(bq);
    chk("after ovf num", 32'(tx_byte_num), 32'd4);
    step();
    req();
    chk("after ovf w0", tx_data, 32'h11223344);
    done();

    bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wbytes(bq);
    wr_en = 1'b1;
    wr_data = 8'h55;
    step();
    req();
    chk("hold w0", tx_data, 32'hA1A2A3A4);
    req();
    chk("hold busy", 32'(busy), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wr_en = 1'b0;
    bq = '{8'hC1, 8'hC2, 8'hC3};
    wbytes(bq);
    chk("next num", 32'(tx_byte_num), 32'd3);
    step();
    req();
    chk("next w0", tx_data, 32'hC1C2C300);
    done();

    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(8'h20 + i));
    wbytes(bq);
    step();
    req();
    req();
    req();
    chk("p12 w2", tx_data, 32'h28292A2B);
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1;
    step();
    chk("post rst ready", 32'(wr_ready), 32'd1);
    done();
    chk("late done ready", 32'(wr_ready), 32'd1);
    chk("late done busy", 32'(busy), 32'd0);

    bq = '{8'h7F};
    wbytes(bq);
    chk("p1 num", 32'(tx_byte_num), 32'd1);
    step();
    req();
    chk("p1 w0", tx_data, 32'h7F000000);
    done();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
